instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential RV32I instruction encoder and program writer: accepts decoded instruction fields over a valid/ready handshake, packs them into 32-bit RV32I words, and writes them to consecutive word addresses of instruction memory. It is the write-side counterpart of the core's main opcode decoder. It uses the same eight instruction classes and opcodes, so any word it emits decodes back to the same class. It sits between the testbench or boot-loader front end and the instruction-memory write port.

## Interface
- ADDR_W, 12: instruction-memory byte-address width; addresses wrap modulo 2^ADDR_W.
- clk  in  1  rising-edge clock; one clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept; transfer occurs when in_valid && in_ready.
- in_type  in  3  class: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 B, 5 JAL, 6 LUI, 7 JALR.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3; funct7  in  7.
- imm  in  32  signed byte immediate (LUI: full upper value).
- load_start  in  1  single-cycle pulse: flush, set address, clear status.
- start_addr  in  ADDR_W  new write address; bits [1:0] are ignored and forced to 00.
- wr_en  out  1  write request to instruction memory.
- wr_ready  in  1  memory accepts write; write completes when wr_en && wr_ready.
- wr_addr  out  ADDR_W  word-aligned write address.
- wr_data  out  32  encoded instruction.
- err  out  1  sticky: an immediate was illegal for its class.
- words_written  out  16  completed writes; wraps at 2^16.
- busy  out  1  FIFO non-empty.

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, B 1100011, JAL 1101111, LUI 0110111, JALR 1100111.
- R: funct7, rs2, rs1, funct3, rd, opcode.
- I, LOAD: imm[11:0] goes to [31:20], then rs1, funct3, rd. JALR uses the same layout with funct3 forced to 000.
- STORE: imm[11:5] goes to [31:25] and imm[4:0] to [11:7], plus rs2, rs1, funct3.
- B: imm[12] to [31], imm[10:5] to [30:25], imm[4:1] to [11:8], imm[11] to [7], plus rs2, rs1, funct3.
- JAL: imm[20], imm[10:1], imm[11], imm[19:12] go to [31:12], plus rd.
- LUI: imm[31:12] goes to [31:12], plus rd.
- Legality rules (violation: the transfer is consumed, nothing is written, err is set):
  - I, LOAD, STORE, JALR: imm must fit signed 12 bits.
  - B: imm must fit signed 13 bits and imm[0]=0.
  - JAL: imm must fit signed 21 bits and imm[0]=0.
  - LUI: imm[11:0] must be 0.
- Unused fields for a class are ignored.
- Accepted legal words enter a 2-entry FIFO. The FIFO head drives wr_data and wr_addr, and wr_en = busy.
- On a completed write: pop the FIFO, wr_addr += 4 (wrapping), words_written += 1.
- load_start:
  - Empties the FIFO, discarding pending words.
  - Sets wr_addr = {start_addr[ADDR_W-1:2], 00}, err = 0, words_written = 0.
  - Forces in_ready = 0 that cycle.
  - Takes priority over any simultaneous push or pop; a write completing in the same cycle is not counted.

## Timing
- Reset values: in_ready=1, wr_en=0, wr_addr=0, wr_data=0, err=0, words_written=0, busy=0.
- Latency: a field transfer in cycle T makes the word visible on wr_data with wr_en=1 in cycle T+1. Encoding and legality checking are registered at the FIFO push.
- in_ready = (FIFO count != 2) && !load_start. There is no pass-through when the FIFO is full and popping in the same cycle.
- With count=1, a simultaneous push and pop leaves count at 1 and ordering is preserved.
- err is set in T+1 after an illegal transfer. A legal push in the same cycle is unaffected.
- wr_addr, wr_data, and wr_en are held stable while wr_en=1 and wr_ready=0.
- Asserting rst_n mid-operation asynchronously returns all state to reset values. Pending words are lost.

## Test plan
- Reset: hold rst_n=0 with random inputs. All outputs must hold their reset values, and in_ready=1 after release.
- R/I encode:
  - add x3,x1,x2 (type 0, funct3 0, funct7 0) must write 0x002081B3 at addr 0.
  - addi x5,x0,imm=-1 (type 1) must write 0xFFF00293 at addr 4.
  - words_written must then be 2.
- B/JAL/LUI legality:
  - beq x1,x2,+8 must write 0x00208463.
  - jal x1,+2048 must write 0x001000EF.
  - lui x10,0x12345000 must write 0x12345537.
  - beq with imm=7 must produce no write and err=1.
- Backpressure: hold wr_ready=0 and push 3 ops.
  - in_ready must fall after the 2nd accept, and the 3rd op must be held.
  - Release wr_ready: writes must occur at 0, 4, 8 in order.
- load_start mid-operation: with 2 words pending and err=1, pulse load_start with start_addr=0x103.
  - FIFO must empty, wr_addr must be 0x100, and err and words_written must be 0.
  - A field transfer in the same cycle must be refused.
- Wrap: start_addr=0xFFC, then write 2 words. They must land at 0xFFC and 0x000.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder and program writer: packs decoded fields into 32-bit words,
// queues them in a 2-entry FIFO and streams them to consecutive instruction-memory words.
module instr_encoder #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_type,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              err,
    output logic [15:0]       words_written,
    output logic              busy
);

    typedef enum logic [2:0] {
        TyR      = 3'd0,
        TyIAlu   = 3'd1,
        TyLoad   = 3'd2,
        TyStore  = 3'd3,
        TyBranch = 3'd4,
        TyJal    = 3'd5,
        TyLui    = 3'd6,
        TyJalr   = 3'd7
    } instr_type_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpIAlu   = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    logic [31:0]       fifo_q [2];
    logic [31:0]       fifo_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [15:0]       words_q, words_d;

    logic [31:0] enc_word;
    logic        enc_legal;
    logic        fit12, fit13, fit21;
    logic        accept, push, pop;

    // An immediate fits N signed bits when all bits above N-1 equal the sign bit.
    assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (instr_type_e'(in_type))
            TyR: begin
                enc_word = {funct7, rs2, rs1, funct3, rd, OpR};
            end
            TyIAlu: begin
                enc_word  = {imm[11:0], rs1, funct3, rd, OpIAlu};
                enc_legal = fit12;
            end
            TyLoad: begin
                enc_word  = {imm[11:0], rs1, funct3, rd, OpLoad};
                enc_legal = fit12;
            end
            TyStore: begin
                enc_word  = {imm[11:5], rs2, rs1, funct3, imm[4:0], OpStore};
                enc_legal = fit12;
            end
            TyBranch: begin
                enc_word  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OpBranch};
                enc_legal = fit13 & ~imm[0];
            end
            TyJal: begin
                enc_word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
                enc_legal = fit21 & ~imm[0];
            end
            TyLui: begin
                enc_word  = {imm[31:12], rd, OpLui};
                enc_legal = ~(|imm[11:0]);
            end
            TyJalr: begin
                enc_word  = {imm[11:0], rs1, 3'b000, rd, OpJalr};
                enc_legal = fit12;
            end
            default: begin
                enc_word  = 32'h0;
                enc_legal = 1'b0;
            end
        endcase
    end

    assign busy     = (count_q != 2'd0);
    assign wr_en    = busy;
    assign in_ready = (count_q != 2'd2) && !load_start;
    assign wr_addr  = addr_q;
    // Show zero rather than a stale entry once the FIFO has drained.
    assign wr_data  = busy ? fifo_q[rd_ptr_q] : 32'h0;
    assign err           = err_q;
    assign words_written = words_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && enc_legal;
    assign pop    = wr_en && wr_ready;

    always_comb begin
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        addr_d   = addr_q;
        err_d    = err_q;
        words_d  = words_q;
        if (load_start) begin
            // Flush wins over any same-cycle push or completed write.
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
            addr_d   = {start_addr[ADDR_W-1:2], 2'b00};
            err_d    = 1'b0;
            words_d  = 16'd0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = enc_word;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
                addr_d   = addr_q + ADDR_W'(4);
                words_d  = words_q + 16'd1;
            end
            if (accept && !enc_legal) begin
                err_d = 1'b1;
            end
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q[0] <= 32'h0;
            fifo_q[1] <= 32'h0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            words_q   <= 16'd0;
        end else begin
            fifo_q[0] <= fifo_d[0];
            fifo_q[1] <= fifo_d[1];
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            words_q   <= words_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, corner-case sequences and a randomized
// run checked against an arithmetic reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        load_start;
    logic [11:0] start_addr;
    logic        wr_en;
    logic        wr_ready;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [15:0] words_written;
    logic        busy;

    instr_encoder #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
        .imm(imm), .load_start(load_start), .start_addr(start_addr), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .err(err),
        .words_written(words_written), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  ty;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[11];

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [11:0] exp_addr;
    logic        exp_err;
    logic [15:0] exp_ww;
    bit          model_on = 0;
    bit          last_accept;
    logic [11:0] obs_addr[$];
    logic [31:0] obs_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic void ref_encode(input int ty, input int rdv, input int rs1v,
                                       input int rs2v, input int f3, input int f7,
                                       input logic [31:0] immv, output bit legal,
                                       output logic [31:0] w);
        longint s;
        longint r;
        s = longint'(signed'(immv));
        r = 0;
        legal = 1;
        case (ty)
            0: r = f7 * 2**25 + rs2v * 2**20 + rs1v * 2**15 + f3 * 2**12 + rdv * 2**7 + 'h33;
            1, 2, 7: begin
                legal = (s >= -2048) && (s <= 2047);
                r = (s & 'hFFF) * 2**20 + rs1v * 2**15 + ((ty == 7) ? 0 : f3) * 2**12
                    + rdv * 2**7 + ((ty == 1) ? 'h13 : (ty == 2) ? 'h03 : 'h67);
            end
            3: begin
                legal = (s >= -2048) && (s <= 2047);
                r = ((s >> 5) & 'h7F) * 2**25 + rs2v * 2**20 + rs1v * 2**15 + f3 * 2**12
                    + (s & 'h1F) * 2**7 + 'h23;
            end
            4: begin
                legal = (s >= -4096) && (s <= 4095) && ((s & 1) == 0);
                r = ((s >> 12) & 1) * 2**31 + ((s >> 5) & 'h3F) * 2**25 + rs2v * 2**20
                    + rs1v * 2**15 + f3 * 2**12 + ((s >> 1) & 'hF) * 2**8
                    + ((s >> 11) & 1) * 2**7 + 'h63;
            end
            5: begin
                legal = (s >= -(2**20)) && (s < 2**20) && ((s & 1) == 0);
                r = ((s >> 20) & 1) * 2**31 + ((s >> 1) & 'h3FF) * 2**21
                    + ((s >> 11) & 1) * 2**20 + ((s >> 12) & 'hFF) * 2**12 + rdv * 2**7 + 'h6F;
            end
            default: begin
                legal = (s % 4096) == 0;
                r = ((s >> 12) & 'hFFFFF) * 2**12 + rdv * 2**7 + 'h37;
            end
        endcase
        w = r[31:0];
    endfunction

    // One clock: model/checks at the falling edge, then inputs may change after the rise.
    task automatic cycle();
        bit          leg;
        logic [31:0] w;
        @(negedge clk);
        last_accept = in_valid && in_ready;
        if (wr_en && wr_ready && !load_start) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
        end
        if (model_on) begin
            check("busy", busy, 32'(exp_q.size() != 0));
            check("wr_en", wr_en, 32'(exp_q.size() != 0));
            check("err", err, exp_err);
            check("words_written", words_written, exp_ww);
            check("wr_addr", wr_addr, exp_addr);
            check("in_ready", in_ready, 32'((exp_q.size() != 2) && !load_start));
            if (load_start) begin
                exp_q.delete();
                exp_addr = start_addr & 12'hFFC;
                exp_err  = 0;
                exp_ww   = 0;
            end else begin
                if (wr_en && wr_ready) begin
                    if (exp_q.size() == 0) check("write_with_nothing_pending", wr_en, 0);
                    else begin
                        check("wr_data", wr_data, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                    exp_addr = exp_addr + 12'd4;
                    exp_ww   = exp_ww + 16'd1;
                end
                if (in_valid && in_ready) begin
                    ref_encode(int'(in_type), int'(rd), int'(rs1), int'(rs2), int'(funct3),
                               int'(funct7), imm, leg, w);
                    if (leg) exp_q.push_back(w);
                    else exp_err = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input vec_t v);
        in_type = v.ty; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        funct3 = v.f3; funct7 = v.f7; imm = v.imm;
    endtask

    task automatic set_op(input int ty, input int rdv, input int rs1v, input int rs2v,
                          input int f3, input logic [31:0] immv);
        in_type = 3'(ty); rd = 5'(rdv); rs1 = 5'(rs1v); rs2 = 5'(rs2v);
        funct3 = 3'(f3); funct7 = 7'd0; imm = immv;
    endtask

    task automatic send();
        bit ok = 0;
        in_valid = 1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_accept) begin ok = 1; break; end
        end
        in_valid = 0;
        if (!ok) check("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && busy; n++) cycle();
        check("drained", busy, 0);
    endtask

    task automatic do_load(input logic [11:0] a);
        load_start = 1;
        start_addr = a;
        cycle();
        load_start = 0;
        obs_addr.delete();
        obs_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_words_written"}, words_written, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic randomize_inputs(input bit allow_load);
        in_valid   = ($urandom_range(0, 9) < 7);
        wr_ready   = ($urandom_range(0, 9) < 6);
        load_start = allow_load && ($urandom_range(0, 49) == 0);
        start_addr = 12'($urandom);
        in_type    = 3'($urandom);
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1: imm = $urandom;
            2: imm = (32'($urandom_range(0, 2**22 - 1)) - 32'(2**21)) & 32'hFFFF_FFFE;
            default: imm = $urandom & 32'hFFFF_F000;
        endcase
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_addr = 0;
        exp_err  = 0;
        exp_ww   = 0;
    endtask

    initial begin
        logic [11:0] a;
        logic        sticky;

        vecs[0]  = '{"add",       0, 3, 1, 2, 0, 0, 32'd0,          1, 32'h002081B3};
        vecs[1]  = '{"addi_m1",   1, 5, 0, 0, 0, 0, 32'hFFFF_FFFF,  1, 32'hFFF00293};
        vecs[2]  = '{"beq_p8",    4, 0, 1, 2, 0, 0, 32'd8,          1, 32'h00208463};
        vecs[3]  = '{"jal_2048",  5, 1, 0, 0, 0, 0, 32'd2048,       1, 32'h001000EF};
        vecs[4]  = '{"lui",       6, 10, 0, 0, 0, 0, 32'h12345000,  1, 32'h12345537};
        vecs[5]  = '{"beq_odd",   4, 0, 1, 2, 0, 0, 32'd7,          0, 32'h0};
        vecs[6]  = '{"sw_m4",     3, 0, 1, 2, 2, 0, 32'hFFFF_FFFC,  1, 32'hFE20AE23};
        vecs[7]  = '{"lw_8",      2, 6, 2, 0, 2, 0, 32'd8,          1, 32'h00812303};
        vecs[8]  = '{"jalr_f3",   7, 1, 5, 0, 7, 0, 32'd0,          1, 32'h000280E7};
        vecs[9]  = '{"addi_2048", 1, 1, 1, 0, 0, 0, 32'd2048,       0, 32'h0};
        vecs[10] = '{"lui_low",   6, 1, 0, 0, 0, 0, 32'h0000_1001,  0, 32'h0};

        // Reset held with random inputs.
        rst_n = 0;
        for (int i = 0; i < 4; i++) begin
            randomize_inputs(0);
            @(negedge clk);
            check_reset_outputs("reset");
            @(posedge clk);
            #1;
        end
        in_valid = 0; wr_ready = 0; load_start = 0; start_addr = 0;
        rst_n = 1;
        model_reset();
        model_on = 1;
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;

        // Vector table.
        wr_ready = 1;
        do_load(12'h000);
        a = 0;
        sticky = 0;
        foreach (vecs[i]) begin
            obs_addr.delete();
            obs_data.delete();
            set_vec(vecs[i]);
            send();
            drain();
            if (vecs[i].legal) begin
                check({vecs[i].name, "_nwrites"}, obs_data.size(), 1);
                if (obs_data.size() == 1) begin
                    check({vecs[i].name, "_data"}, obs_data[0], vecs[i].word);
                    check({vecs[i].name, "_addr"}, obs_addr[0], a);
                end
                a = a + 12'd4;
            end else begin
                sticky = 1;
                check({vecs[i].name, "_nwrites"}, obs_data.size(), 0);
            end
            check({vecs[i].name, "_err"}, err, sticky);
            if (i == 1) check("ww_after_two", words_written, 2);
        end

        // Backpressure: third op held until the FIFO frees.
        do_load(12'h000);
        wr_ready = 0;
        in_valid = 1;
        set_op(1, 1, 0, 0, 0, 32'd1);
        cycle();
        check("bp_accept1", last_accept, 1);
        set_op(1, 2, 0, 0, 0, 32'd2);
        cycle();
        check("bp_accept2", last_accept, 1);
        set_op(1, 3, 0, 0, 0, 32'd3);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_third_held", last_accept, 0);
        end
        wr_ready = 1;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (last_accept) break;
        end
        in_valid = 0;
        drain();
        check("bp_nwrites", obs_data.size(), 3);
        if (obs_data.size() == 3) begin
            check("bp_addr0", obs_addr[0], 12'h000);
            check("bp_addr1", obs_addr[1], 12'h004);
            check("bp_addr2", obs_addr[2], 12'h008);
            check("bp_data0", obs_data[0], 32'h00100093);
            check("bp_data1", obs_data[1], 32'h00200113);
            check("bp_data2", obs_data[2], 32'h00300193);
        end

        // load_start with two pending words and err set.
        do_load(12'h000);
        wr_ready = 0;
        set_op(4, 0, 1, 2, 0, 32'd7);
        send();
        set_op(1, 4, 0, 0, 0, 32'd4);
        send();
        set_op(1, 5, 0, 0, 0, 32'd5);
        send();
        check("ls_pre_busy", busy, 1);
        check("ls_pre_err", err, 1);
        in_valid = 1;
        set_op(1, 6, 0, 0, 0, 32'd6);
        load_start = 1;
        start_addr = 12'h103;
        cycle();
        check("ls_transfer_refused", last_accept, 0);
        load_start = 0;
        in_valid = 0;
        obs_addr.delete();
        obs_data.delete();
        check("ls_busy", busy, 0);
        check("ls_wr_addr", wr_addr, 12'h100);
        check("ls_err", err, 0);
        check("ls_ww", words_written, 0);
        wr_ready = 1;
        for (int i = 0; i < 3; i++) cycle();
        check("ls_no_writes", obs_data.size(), 0);

        // Address wrap.
        do_load(12'hFFC);
        set_op(1, 7, 0, 0, 0, 32'd7);
        send();
        set_op(1, 8, 0, 0, 0, 32'd8);
        send();
        drain();
        check("wrap_nwrites", obs_data.size(), 2);
        if (obs_data.size() == 2) begin
            check("wrap_addr0", obs_addr[0], 12'hFFC);
            check("wrap_addr1", obs_addr[1], 12'h000);
        end

        // Randomized run against the reference model.
        for (int i = 0; i < 1500; i++) begin
            randomize_inputs(1);
            cycle();
        end

        // Asynchronous reset mid-operation.
        in_valid = 1; wr_ready = 0; load_start = 0;
        set_op(0, 1, 2, 3, 0, 32'd0);
        cycle();
        cycle();
        #2;
        rst_n = 0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        for (int i = 0; i < 200; i++) begin
            randomize_inputs(1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
